// File: rtl/motion_sequencer.sv
// motion_sequencer: queues per-wheel motion commands and issues them one at a
// time to the stepctl drivers, with completion wait, abort and timeout.
module motion_sequencer #(
   parameter int          DEPTH       = 4,
   parameter logic [31:0] ARM_CYC     = 32'd16,
   parameter logic [31:0] TIMEOUT_CYC = 32'd160000000,
   parameter logic [31:0] GAP_CYC     = 32'd160000
) (
   input  logic                     WF_CLK,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_dirL,
   input  logic                     cmd_dirR,
   input  logic [15:0]              cmd_speedL,
   input  logic [15:0]              cmd_speedR,
   input  logic [15:0]              cmd_degreeL,
   input  logic [15:0]              cmd_degreeR,
   input  logic                     abort,
   input  logic                     step_done,
   output logic                     stepctl_en,
   output logic                     driver_sel,
   output logic                     motorL_dir,
   output logic                     motorR_dir,
   output logic [15:0]              speedL,
   output logic [15:0]              speedR,
   output logic [15:0]              degreeL,
   output logic [15:0]              degreeR,
   output logic                     busy,
   output logic                     cmd_complete,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 66;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_ARM   = 3'd2,
      S_RUN   = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [EW-1:0]  mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    cnt_q, cnt_d;
   logic           timeout_q;
   logic           dirl_q, dirr_q;
   logic [15:0]    spdl_q, spdr_q, degl_q, degr_q;

   logic           push, pop, flush, cmd_done, tmo;
   logic           arm_last, gap_last;
   logic [EW-1:0]  wr_entry, rd_entry;

   // Ready is suppressed during reset and abort so a push can never race a flush.
   assign cmd_ready = ~rst & ~abort & (count_q < CW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign wr_entry  = {cmd_dirL, cmd_dirR, cmd_speedL, cmd_speedR, cmd_degreeL, cmd_degreeR};
   assign rd_entry  = mem_q[rd_ptr_q];

   // 33-bit compares keep a zero-length parameter from underflowing.
   assign arm_last = ({1'b0, cnt_q} + 33'd1) >= {1'b0, ARM_CYC};
   assign gap_last = ({1'b0, cnt_q} + 33'd1) >= {1'b0, GAP_CYC};

   // Next-state logic; abort overrides every state and suppresses pop/complete.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      cmd_done = 1'b0;
      tmo      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_ARM;
         S_ARM: begin
            if (!step_done) begin
               state_d = S_RUN;
            end else if (arm_last) begin
               // stepctl never went busy: treat as a zero-length move
               cmd_done = 1'b1;
               state_d  = S_GAP;
            end
         end
         S_RUN: begin
            if (step_done) begin
               cmd_done = 1'b1;
               state_d  = S_GAP;
            end else if (cnt_q >= TIMEOUT_CYC) begin
               tmo     = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d  = S_IDLE;
         pop      = 1'b0;
         cmd_done = 1'b0;
         tmo      = 1'b0;
      end
   end

   assign flush = abort | tmo;

   // Per-state cycle counter: restarts on every state change, saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)  cnt_d = '0;
      else if (cnt_q != '1)    cnt_d = cnt_q + 32'd1;
   end

   // FIFO occupancy follows push/pop; simultaneous push and pop cancel.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Command storage has no reset so it can map onto RAM.
   always_ff @(posedge WF_CLK) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // State, counters, FIFO pointers and the sticky timeout flag.
   always_ff @(posedge WF_CLK or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (tmo) timeout_q <= 1'b1;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
         end
      end
   end

   // Current-command registers: loaded on pop, cleared on abort or timeout.
   always_ff @(posedge WF_CLK or posedge rst) begin
      if (rst) begin
         dirl_q <= 1'b0;
         dirr_q <= 1'b0;
         spdl_q <= '0;
         spdr_q <= '0;
         degl_q <= '0;
         degr_q <= '0;
      end else if (flush) begin
         dirl_q <= 1'b0;
         dirr_q <= 1'b0;
         spdl_q <= '0;
         spdr_q <= '0;
         degl_q <= '0;
         degr_q <= '0;
      end else if (pop) begin
         dirl_q <= rd_entry[65];
         dirr_q <= rd_entry[64];
         spdl_q <= rd_entry[63:48];
         spdr_q <= rd_entry[47:32];
         degl_q <= rd_entry[31:16];
         degr_q <= rd_entry[15:0];
      end
   end

   assign stepctl_en   = (state_q == S_ISSUE);
   assign driver_sel   = (state_q != S_IDLE);
   assign motorL_dir   = dirl_q;
   assign motorR_dir   = dirr_q;
   assign speedL       = spdl_q;
   assign speedR       = spdr_q;
   assign degreeL      = (state_q == S_ISSUE) ? degl_q : 16'd0;
   assign degreeR      = (state_q == S_ISSUE) ? degr_q : 16'd0;
   assign busy         = (state_q != S_IDLE) | (count_q != '0);
   assign cmd_complete = cmd_done;
   assign timeout_err  = timeout_q;
   assign fifo_count   = count_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed, table-driven bench for motion_sequencer with short GAP/TIMEOUT.
module tb_motion_sequencer;

   localparam int          DEPTH = 4;
   localparam logic [31:0] ARM_N = 32'd16;
   localparam logic [31:0] TMO_N = 32'd1000;
   localparam logic [31:0] GAP_N = 32'd20;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic        cmd_dirL, cmd_dirR;
   logic [15:0] cmd_speedL, cmd_speedR, cmd_degreeL, cmd_degreeR;
   logic        abort, step_done;
   logic        stepctl_en, driver_sel, motorL_dir, motorR_dir;
   logic [15:0] speedL, speedR, degreeL, degreeR;
   logic        busy, cmd_complete, timeout_err;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   motion_sequencer #(
      .DEPTH(DEPTH), .ARM_CYC(ARM_N), .TIMEOUT_CYC(TMO_N), .GAP_CYC(GAP_N)
   ) dut (
      .WF_CLK(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dirL(cmd_dirL), .cmd_dirR(cmd_dirR),
      .cmd_speedL(cmd_speedL), .cmd_speedR(cmd_speedR),
      .cmd_degreeL(cmd_degreeL), .cmd_degreeR(cmd_degreeR),
      .abort(abort), .step_done(step_done),
      .stepctl_en(stepctl_en), .driver_sel(driver_sel),
      .motorL_dir(motorL_dir), .motorR_dir(motorR_dir),
      .speedL(speedL), .speedR(speedR),
      .degreeL(degreeL), .degreeR(degreeR),
      .busy(busy), .cmd_complete(cmd_complete),
      .timeout_err(timeout_err), .fifo_count(fifo_count)
   );

   typedef struct packed {
      logic        v;
      logic        sd;
      logic        ab;
      logic        rdy;
      logic        en;
      logic        dsel;
      logic        cc;
      logic        bsy;
      logic [2:0]  cnt;
      logic [15:0] degl;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge; an accepted push drops cmd_valid.
   task automatic tick();
      logic acc;
      acc = cmd_valid & cmd_ready;
      @(posedge clk);
      #1;
      if (acc) cmd_valid = 1'b0;
      #1;
   endtask

   // Command k: alternating directions, distinct speeds and degrees.
   task automatic set_cmd(input int k);
      cmd_dirL    = k[0];
      cmd_dirR    = ~k[0];
      cmd_speedL  = 16'(1000 + k);
      cmd_speedR  = 16'(2000 + k);
      cmd_degreeL = 16'(300 + k);
      cmd_degreeR = 16'(400 + k);
   endtask

   task automatic push_cmd(input int k);
      set_cmd(k);
      cmd_valid = 1'b1;
      tick();
   endtask

   task automatic wait_en(input int bound, output int n);
      n = 0;
      while (!stepctl_en && n < bound) begin
         tick();
         n++;
      end
      check("issue_seen", {31'd0, stepctl_en}, 32'd1);
   endtask

   // From the ISSUE cycle: stepctl goes busy, then finishes a couple of cycles later.
   task automatic run_one();
      step_done = 1'b0;
      tick();
      tick();
      step_done = 1'b1;
      #1;
      check("run_complete", {31'd0, cmd_complete}, 32'd1);
      tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      vec_t vecs [5];
      int   n, m, bad;
      int   exp_cnt [6];

      // rows: inputs {valid, step_done, abort} then expected outputs
      vecs[0] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};   // idle, push
      vecs[1] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0};   // queued, pop
      vecs[2] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'd240}; // ISSUE
      vecs[3] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0};   // ARM
      vecs[4] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0};   // RUN

      exp_cnt[1] = 3; exp_cnt[2] = 3; exp_cnt[3] = 2; exp_cnt[4] = 1; exp_cnt[5] = 0;

      rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; step_done = 1'b1;
      set_cmd(0);
      tick(); tick();
      check("rst_ready",   {31'd0, cmd_ready},   32'd0);
      check("rst_dsel",    {31'd0, driver_sel},  32'd0);
      check("rst_busy",    {31'd0, busy},        32'd0);
      check("rst_count",   {29'd0, fifo_count},  32'd0);
      check("rst_tmo",     {31'd0, timeout_err}, 32'd0);
      check("rst_speedL",  {16'd0, speedL},      32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // Single command, cycle by cycle from the push to RUN.
      cmd_dirL = 1'b0; cmd_dirR = 1'b1;
      cmd_speedL = 16'd360; cmd_speedR = 16'd180;
      cmd_degreeL = 16'd240; cmd_degreeR = 16'd120;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = vecs[i].v;
         step_done = vecs[i].sd;
         abort     = vecs[i].ab;
         #1;
         check($sformatf("v%0d_ready", i), {31'd0, cmd_ready},    {31'd0, vecs[i].rdy});
         check($sformatf("v%0d_en", i),    {31'd0, stepctl_en},   {31'd0, vecs[i].en});
         check($sformatf("v%0d_dsel", i),  {31'd0, driver_sel},   {31'd0, vecs[i].dsel});
         check($sformatf("v%0d_cc", i),    {31'd0, cmd_complete}, {31'd0, vecs[i].cc});
         check($sformatf("v%0d_busy", i),  {31'd0, busy},         {31'd0, vecs[i].bsy});
         check($sformatf("v%0d_count", i), {29'd0, fifo_count},  {29'd0, vecs[i].cnt});
         check($sformatf("v%0d_degL", i),  {16'd0, degreeL},      {16'd0, vecs[i].degl});
         if (i == 2) check("v2_degR", {16'd0, degreeR}, 32'd120);
         $display("vector %0d: en=%0d dsel=%0d busy=%0d count=%0d degL=%0d",
                  i, stepctl_en, driver_sel, busy, fifo_count, degreeL);
         tick();
      end
      // step_done low for 100 cycles in total (one ARM + 99 RUN cycles)
      bad = 0;
      for (int i = 0; i < 98; i++) begin
         if (cmd_complete) bad++;
         tick();
      end
      check("no_early_complete", bad, 0);
      step_done = 1'b1;
      #1;
      check("t1_complete", {31'd0, cmd_complete}, 32'd1);
      check("t1_speedL",   {16'd0, speedL}, 32'd360);
      check("t1_speedR",   {16'd0, speedR}, 32'd180);
      check("t1_dirR",     {31'd0, motorR_dir}, 32'd1);
      tick();
      check("t1_cc_single", {31'd0, cmd_complete}, 32'd0);
      check("t1_gap_dsel",  {31'd0, driver_sel},   32'd1);
      n = 1;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("t1_gap_len", n, 32'(GAP_N + 1));
      check("t1_idle_dsel", {31'd0, driver_sel}, 32'd0);
      $display("cmd 1 complete, idle after %0d cycles", n);

      // Fill the FIFO while a command runs; order and wrap-around.
      push_cmd(0);
      wait_en(10, n);
      check("A_degL", {16'd0, degreeL}, 32'd300);
      step_done = 1'b0;
      tick();
      tick();
      for (int k = 1; k <= 4; k++) begin
         set_cmd(k);
         cmd_valid = 1'b1;
         #1;
         check($sformatf("fill%0d_ready", k), {31'd0, cmd_ready}, 32'd1);
         tick();
         check($sformatf("fill%0d_count", k), {29'd0, fifo_count}, 32'(k));
      end
      set_cmd(5);
      cmd_valid = 1'b1;
      #1;
      check("full_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      check("full_count", {29'd0, fifo_count}, 32'd4);
      step_done = 1'b1;
      #1;
      check("A_complete", {31'd0, cmd_complete}, 32'd1);
      tick();
      for (int k = 1; k <= 5; k++) begin
         wait_en(40, n);
         check($sformatf("order%0d_degL", k),   {16'd0, degreeL},    32'(300 + k));
         check($sformatf("order%0d_degR", k),   {16'd0, degreeR},    32'(400 + k));
         check($sformatf("order%0d_speedL", k), {16'd0, speedL},     32'(1000 + k));
         check($sformatf("order%0d_dirL", k),   {31'd0, motorL_dir}, 32'(k % 2));
         check($sformatf("order%0d_count", k),  {29'd0, fifo_count}, 32'(exp_cnt[k]));
         $display("issued cmd %0d: degL=%0d count=%0d", k, degreeL, fifo_count);
         run_one();
      end
      wait_idle();
      check("fill_empty", {29'd0, fifo_count}, 32'd0);

      // Abort during RUN with two commands queued.
      push_cmd(6);
      wait_en(10, n);
      step_done = 1'b0;
      tick();
      tick();
      push_cmd(20);
      push_cmd(21);
      check("ab_queued", {29'd0, fifo_count}, 32'd2);
      abort = 1'b1;
      set_cmd(22);
      cmd_valid = 1'b1;
      step_done = 1'b1;
      #1;
      check("ab_ready", {31'd0, cmd_ready},    32'd0);
      check("ab_no_cc", {31'd0, cmd_complete}, 32'd0);
      tick();
      check("ab_dsel",   {31'd0, driver_sel}, 32'd0);
      check("ab_count",  {29'd0, fifo_count}, 32'd0);
      check("ab_speedL", {16'd0, speedL},     32'd0);
      check("ab_speedR", {16'd0, speedR},     32'd0);
      check("ab_dirR",   {31'd0, motorR_dir}, 32'd0);
      check("ab_busy",   {31'd0, busy},       32'd0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fifo_count != 0 || stepctl_en || driver_sel || cmd_complete) bad++;
      end
      check("ab_hold_nothing", bad, 0);
      abort = 1'b0;
      cmd_valid = 1'b0;
      tick();
      check("ab_after_busy", {31'd0, busy}, 32'd0);
      $display("abort flushed queue");

      // Zero-length move: step_done never falls; ARM gives up after ARM_CYC cycles.
      set_cmd(7);
      cmd_degreeL = 16'd0;
      cmd_degreeR = 16'd0;
      cmd_valid = 1'b1;
      tick();
      push_cmd(8);
      check("z_en",    {31'd0, stepctl_en}, 32'd1);
      check("z_degL",  {16'd0, degreeL},    32'd0);
      check("z_count", {29'd0, fifo_count}, 32'd1);
      n = 0;
      while (!cmd_complete && n < 40) begin
         tick();
         n++;
      end
      check("z_arm_len", n, 32'(ARM_N));
      m = 0;
      while (!stepctl_en && m < 40) begin
         tick();
         m++;
      end
      check("z_next_issue_gap", m, 32'(GAP_N + 2));
      check("z_next_degL", {16'd0, degreeL}, 32'd308);
      $display("zero move done after %0d ARM cycles, next issue %0d cycles later", n, m);
      run_one();
      wait_idle();

      // Timeout: step_done never returns high.
      push_cmd(9);
      push_cmd(10);
      check("to_issue", {31'd0, stepctl_en}, 32'd1);
      step_done = 1'b0;
      tick();
      tick();
      n = 1;  // now in RUN cycle 1
      while (!timeout_err && n < 1100) begin
         tick();
         n++;
      end
      // flag registers at the edge closing RUN cycle TMO_N+1, visible one cycle later
      check("to_cycle",  n, 32'(TMO_N + 2));
      check("to_count",  {29'd0, fifo_count}, 32'd0);
      check("to_busy",   {31'd0, busy},       32'd0);
      check("to_dsel",   {31'd0, driver_sel}, 32'd0);
      check("to_speedL", {16'd0, speedL},     32'd0);
      for (int i = 0; i < 5; i++) tick();
      check("to_sticky", {31'd0, timeout_err}, 32'd1);
      $display("timeout flagged at RUN cycle %0d", n - 1);

      // Asynchronous reset between clock edges mid-RUN.
      step_done = 1'b1;
      push_cmd(12);
      wait_en(10, n);
      step_done = 1'b0;
      tick();
      tick();
      check("ar_run_dsel", {31'd0, driver_sel}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_dsel",   {31'd0, driver_sel},  32'd0);
      check("ar_speedL", {16'd0, speedL},      32'd0);
      check("ar_dirR",   {31'd0, motorR_dir},  32'd0);
      check("ar_busy",   {31'd0, busy},        32'd0);
      check("ar_tmo",    {31'd0, timeout_err}, 32'd0);
      check("ar_ready",  {31'd0, cmd_ready},   32'd0);
      tick();
      rst = 1'b0;
      step_done = 1'b1;
      #1;
      check("ar_ready_back", {31'd0, cmd_ready}, 32'd1);
      push_cmd(13);
      wait_en(10, n);
      check("ar_resume_degL", {16'd0, degreeL}, 32'd313);
      run_one();
      wait_idle();
      $display("reset recovery command complete");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
